jt12_snd_fifo: RTL and testbench

- Output-side stage directly downstream of the per-channel saturating accumulators.
- Captures the left/right `snd` words each time the accumulators close a sample (`zero` strobe qualified by `clk_en`).
- Applies a power-of-two gain with saturation, then buffers stereo samples in a small FIFO.
- Hands samples to the downstream mixer/DAC with a valid/ready handshake, and counts dropped samples.

---
 rtl/jt12_snd_fifo.sv | 121 ++++++++++++
 tb/tb_jt12_snd_fifo.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/jt12_snd_fifo.sv
// Stereo sample capture stage behind the jt12 accumulators.
// Gain and saturation on capture, a small FIFO, and a valid/ready output.
module jt12_snd_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clk_en,
    input  logic             zero,
    input  logic [WIDTH-1:0] snd_left,
    input  logic [WIDTH-1:0] snd_right,
    input  logic [1:0]       gain,
    output logic [WIDTH-1:0] out_left,
    output logic [WIDTH-1:0] out_right,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       drop_cnt,
    output logic [AW:0]      level
);

    localparam logic signed [WIDTH+2:0] MAXV = {4'b0000, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH+2:0] MINV = {4'b1111, {(WIDTH-1){1'b0}}};
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    function automatic logic [WIDTH-1:0] sat(
        input logic [WIDTH-1:0] s,
        input logic [1:0]       sh
    );
        logic signed [WIDTH+2:0] g;
        g = $signed({{3{s[WIDTH-1]}}, s}) <<< sh;
        if (g > MAXV)
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        else if (g < MINV)
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        else
            sat = g[WIDTH-1:0];
    endfunction

    logic [2*WIDTH-1:0] mem_q [DEPTH];
    logic               cap_pend_q;
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        level_q, level_d;
    logic [7:0]         drop_q, drop_d;
    logic               valid_q;
    logic [WIDTH-1:0]   out_l_q, out_r_q;
    logic [WIDTH-1:0]   out_l_d, out_r_d;

    logic               full, rd_fire, wr_en, drop;
    logic [2*WIDTH-1:0] wdata, head_d;

    always_comb begin
        full    = (level_q == FULL_LVL);
        rd_fire = valid_q & out_ready;
        wr_en   = cap_pend_q & (~full | rd_fire);
        drop    = cap_pend_q & full & ~rd_fire;
        wdata   = {sat(snd_left, gain), sat(snd_right, gain)};

        wr_ptr_d = wr_en   ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = rd_fire ? rd_ptr_q + AW'(1) : rd_ptr_q;

        level_d = level_q;
        if (wr_en && !rd_fire)
            level_d = level_q + (AW+1)'(1);
        else if (!wr_en && rd_fire)
            level_d = level_q - (AW+1)'(1);

        drop_d = drop_q;
        if (drop && drop_q != 8'hFF)
            drop_d = drop_q + 8'd1;

        // New head may be the word being written this very cycle
        if (wr_en && wr_ptr_q == rd_ptr_d)
            head_d = wdata;
        else
            head_d = mem_q[rd_ptr_d];

        out_l_d = out_l_q;
        out_r_d = out_r_q;
        if (level_d != '0 && (rd_fire || level_q == '0)) begin
            out_l_d = head_d[2*WIDTH-1:WIDTH];
            out_r_d = head_d[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cap_pend_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            drop_q     <= '0;
            valid_q    <= 1'b0;
            out_l_q    <= '0;
            out_r_q    <= '0;
        end else begin
            cap_pend_q <= clk_en & zero;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            drop_q     <= drop_d;
            valid_q    <= (level_d != '0);
            out_l_q    <= out_l_d;
            out_r_q    <= out_r_d;
        end
    end

    assign out_left  = out_l_q;
    assign out_right = out_r_q;
    assign out_valid = valid_q;
    assign drop_cnt  = drop_q;
    assign level     = level_q;

endmodule

// File: tb/tb_jt12_snd_fifo.sv
// Directed bench for jt12_snd_fifo.
// Each task drives one scenario and checks expected values inline.
module tb_jt12_snd_fifo;

    logic        clk = 1'b0;
    logic        rst, clk_en, zero, out_ready, out_valid;
    logic [15:0] snd_left, snd_right, out_left, out_right;
    logic [1:0]  gain;
    logic [7:0]  drop_cnt;
    logic [2:0]  level;

    int total = 0;
    int bad   = 0;

    jt12_snd_fifo #(.WIDTH(16), .DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .clk_en(clk_en), .zero(zero),
        .snd_left(snd_left), .snd_right(snd_right), .gain(gain),
        .out_left(out_left), .out_right(out_right),
        .out_valid(out_valid), .out_ready(out_ready),
        .drop_cnt(drop_cnt), .level(level)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Strobe cycle, then present the sample on the following cycle
    task automatic strobe(input logic [15:0] l, input logic [15:0] r);
        clk_en = 1'b1; zero = 1'b1;
        snd_left = 16'hDEAD; snd_right = 16'hBEEF;
        tick();
        clk_en = 1'b0; zero = 1'b0;
        snd_left = l; snd_right = r;
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clk_en = 0; zero = 0; out_ready = 0; gain = 0;
        snd_left = 0; snd_right = 0;
        tick(); tick();
        rst = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid got=%b exp=0", out_valid); end
        total++; if (level !== 3'd0) begin bad++;
            $display("FAIL reset_level got=%0d exp=0", level); end
        total++; if (drop_cnt !== 8'd0) begin bad++;
            $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
        total++; if ({out_left, out_right} !== 32'h0) begin bad++;
            $display("FAIL reset_out got=%h exp=0", {out_left, out_right}); end
    endtask

    task automatic test_single();
        strobe(16'h1234, 16'hFEDC);
        total++; if (out_valid !== 1'b1) begin bad++;
            $display("FAIL single_valid got=%b exp=1", out_valid); end
        total++; if ({out_left, out_right} !== 32'h1234FEDC) begin bad++;
            $display("FAIL single_data got=%h exp=1234fedc", {out_left, out_right}); end
        total++; if (level !== 3'd1) begin bad++;
            $display("FAIL single_level got=%0d exp=1", level); end
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL single_pop_valid got=%b exp=0", out_valid); end
        total++; if ({out_left, out_right} !== 32'h1234FEDC) begin bad++;
            $display("FAIL single_hold got=%h exp=1234fedc", {out_left, out_right}); end
    endtask

    task automatic test_gain();
        logic [15:0] inl [4];
        logic [15:0] inr [4];
        logic [15:0] exl [4];
        logic [15:0] exr [4];
        inl = '{16'h1000, 16'h2001, 16'hE000, 16'hF000};
        inr = '{16'hF000, 16'hE000, 16'h2001, 16'h1000};
        exl = '{16'h4000, 16'h7FFF, 16'h8000, 16'hC000};
        exr = '{16'hC000, 16'h8000, 16'h7FFF, 16'h4000};
        gain = 2'd2;
        for (int i = 0; i < 4; i++) strobe(inl[i], inr[i]);
        gain = 2'd0;
        for (int i = 0; i < 4; i++) begin
            total++; if (out_left !== exl[i]) begin bad++;
                $display("FAIL gain_left[%0d] got=%h exp=%h", i, out_left, exl[i]); end
            total++; if (out_right !== exr[i]) begin bad++;
                $display("FAIL gain_right[%0d] got=%h exp=%h", i, out_right, exr[i]); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 6; k++) strobe(16'(k), 16'(k + 100));
        total++; if (level !== 3'd4) begin bad++;
            $display("FAIL ovf_level got=%0d exp=4", level); end
        total++; if (drop_cnt !== 8'd2) begin bad++;
            $display("FAIL ovf_drop got=%0d exp=2", drop_cnt); end
        for (int k = 1; k <= 4; k++) begin
            total++; if ({out_valid, out_left, out_right} !== {1'b1, 16'(k), 16'(k + 100)}) begin bad++;
                $display("FAIL ovf_drain[%0d] got=%b/%h/%h exp=1/%h/%h",
                         k, out_valid, out_left, out_right, 16'(k), 16'(k + 100)); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
        total++; if (out_valid !== 1'b0) begin bad++;
            $display("FAIL ovf_empty got=%b exp=0", out_valid); end
        for (int k = 0; k < 304; k++) strobe(16'h0055, 16'h0066);
        total++; if (drop_cnt !== 8'd255) begin bad++;
            $display("FAIL ovf_sat got=%0d exp=255", drop_cnt); end
    endtask

    task automatic test_full_rw();
        logic [7:0] d0;
        do_reset();
        for (int k = 1; k <= 4; k++) strobe(16'(k), 16'(k + 200));
        d0 = drop_cnt;
        clk_en = 1'b1; zero = 1'b1; tick();
        clk_en = 1'b0; zero = 1'b0;
        snd_left = 16'd5; snd_right = 16'd205; out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        total++; if (level !== 3'd4) begin bad++;
            $display("FAIL frw_level got=%0d exp=4", level); end
        total++; if (drop_cnt !== d0) begin bad++;
            $display("FAIL frw_drop got=%0d exp=%0d", drop_cnt, d0); end
        for (int k = 2; k <= 5; k++) begin
            total++; if ({out_left, out_right} !== {16'(k), 16'(k + 200)}) begin bad++;
                $display("FAIL frw_drain[%0d] got=%h/%h exp=%h/%h",
                         k, out_left, out_right, 16'(k), 16'(k + 200)); end
            out_ready = 1'b1; tick(); out_ready = 1'b0;
        end
    endtask

    task automatic test_wrap();
        logic maxlv;
        maxlv = 1'b0;
        out_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            clk_en = 1'b1; zero = 1'b1; tick();
            if (level > 3'd1) maxlv = 1'b1;
            clk_en = 1'b0; zero = 1'b0;
            snd_left = 16'(k); snd_right = 16'(k * 3);
            tick();
            if (level > 3'd1) maxlv = 1'b1;
            total++; if ({out_valid, out_left, out_right} !== {1'b1, 16'(k), 16'(k * 3)}) begin bad++;
                $display("FAIL wrap[%0d] got=%b/%h/%h exp=1/%h/%h",
                         k, out_valid, out_left, out_right, 16'(k), 16'(k * 3)); end
            tick();
            if (level > 3'd1) maxlv = 1'b1;
        end
        out_ready = 1'b0;
        total++; if (maxlv !== 1'b0) begin bad++;
            $display("FAIL wrap_level got=%b exp=0", maxlv); end
        total++; if (drop_cnt !== 8'd0) begin bad++;
            $display("FAIL wrap_drop got=%0d exp=0", drop_cnt); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 1; k <= 9; k++) strobe(16'(k), 16'(k));
        out_ready = 1'b1; tick(); out_ready = 1'b0;
        total++; if ({level, drop_cnt} !== {3'd3, 8'd5}) begin bad++;
            $display("FAIL mrst_pre got=%0d/%0d exp=3/5", level, drop_cnt); end
        rst = 1'b1; clk_en = 1'b1; zero = 1'b1;
        snd_left = 16'h0099; snd_right = 16'h0099;
        tick();
        rst = 1'b0; clk_en = 1'b0; zero = 1'b0;
        tick();
        total++; if ({out_valid, level} !== {1'b0, 3'd0}) begin bad++;
            $display("FAIL mrst_state got=%b/%0d exp=0/0", out_valid, level); end
        total++; if ({out_left, out_right} !== 32'h0) begin bad++;
            $display("FAIL mrst_out got=%h exp=0", {out_left, out_right}); end
        total++; if (drop_cnt !== 8'd0) begin bad++;
            $display("FAIL mrst_drop got=%0d exp=0", drop_cnt); end
        strobe(16'h0077, 16'h0078);
        total++; if ({level, out_left, out_right} !== {3'd1, 16'h0077, 16'h0078}) begin bad++;
            $display("FAIL mrst_after got=%0d/%h/%h exp=1/0077/0078",
                     level, out_left, out_right); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_gain();
        test_overflow();
        test_full_rw();
        test_wrap();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
